// File: rtl/perceptron_neuron.sv
// Sequential single-neuron stage: bias + sum(x*w) over a valid/ready stream, then activation.
// Optional PERCEPTRON_ACC_SATURATE_EN: saturating accumulation with a sticky sat flag.

package FixedPoint;
  typedef logic signed [63:0] sfp;

  localparam sfp SFP_ONE = 64'sh0000_0001_0000_0000;

  // Q32.32 multiply: full signed product, arithmetic shift by 32, wrap to 64 bits
  function automatic sfp sfp_mul(input sfp a, input sfp b);
    logic signed [127:0] ae;
    logic signed [127:0] be;
    logic signed [127:0] p;
    ae = a;
    be = b;
    p  = ae * be;
    return sfp'(p >>> 32);
  endfunction
endpackage

package Common;
  typedef enum logic [1:0] {
    ACT_STEP    = 2'd0,
    ACT_RELU    = 2'd1,
    ACT_SIGMOID = 2'd2,
    ACT_TANH    = 2'd3
  } act_func;
endpackage

module perceptron_neuron #(
  parameter int unsigned N_INPUTS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  Common::act_func     act,
  input  FixedPoint::sfp      bias,
  input  logic                in_valid,
  output logic                in_ready,
  input  FixedPoint::sfp      x,
  input  FixedPoint::sfp      w,
  output logic                out_valid,
  input  logic                out_ready,
  output FixedPoint::sfp      y,
  output logic                busy,
  output logic                sat
);
  import FixedPoint::*;
  import Common::*;

  localparam int unsigned CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_ACT   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  act_func         act_q;
  sfp              acc;
  logic [CW-1:0]   cnt;
  sfp              prod;
  sfp              acc_next;
  sfp              act_y;
  sfp              sig;
  logic            last_beat;

  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign last_beat = (cnt == CW'(N_INPUTS - 1));

`ifdef PERCEPTRON_ACC_SATURATE_EN
  logic        ovf;
  logic [64:0] sum;
  logic        sat_q;

  assign sat = sat_q;

  // Overflow shows up as disagreement between the two top bits of the 65-bit sum
  always_comb begin
    prod     = sfp_mul(x, w);
    sum      = {acc[63], acc} + {prod[63], prod};
    ovf      = (sum[64] != sum[63]);
    acc_next = sum[63:0];
    if (ovf) acc_next = sum[64] ? 64'sh8000_0000_0000_0000 : 64'sh7FFF_FFFF_FFFF_FFFF;
  end
`else
  assign sat = 1'b0;

  always_comb begin
    prod     = sfp_mul(x, w);
    acc_next = acc + prod;
  end
`endif

  always_comb begin
    act_y = '0;
    sig   = (acc >>> 2) + 64'sh0000_0000_8000_0000;
    unique case (act_q)
      ACT_STEP:    act_y = acc[63] ? '0 : SFP_ONE;
      ACT_RELU:    act_y = acc[63] ? '0 : acc;
      ACT_SIGMOID: begin
        if (sig < 0)             act_y = '0;
        else if (sig > SFP_ONE)  act_y = SFP_ONE;
        else                     act_y = sig;
      end
      ACT_TANH: begin
        if (acc < -SFP_ONE)      act_y = -SFP_ONE;
        else if (acc > SFP_ONE)  act_y = SFP_ONE;
        else                     act_y = acc;
      end
      default:                   act_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      act_q <= ACT_STEP;
      acc   <= '0;
      cnt   <= '0;
      y     <= '0;
`ifdef PERCEPTRON_ACC_SATURATE_EN
      sat_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            act_q <= act;
            acc   <= bias;
            cnt   <= '0;
`ifdef PERCEPTRON_ACC_SATURATE_EN
            sat_q <= 1'b0;
`endif
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
`ifdef PERCEPTRON_ACC_SATURATE_EN
            if (ovf) sat_q <= 1'b1;
`endif
            if (last_beat) state <= S_ACT;
          end
        end
        S_ACT: begin
          y     <= act_y;
          state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_neuron.sv
// Self-checking bench for perceptron_neuron: directed vector table, corner sequences, random vs. model.
module tb_perceptron_neuron;
  import FixedPoint::*;
  import Common::*;

  localparam int N = 4;
  localparam logic [63:0] ONE  = 64'h0000_0001_0000_0000;
  localparam logic [63:0] HALF = 64'h0000_0000_8000_0000;

  typedef logic [N-1:0][63:0] vec_t;

  typedef struct {
    act_func     f;
    logic [63:0] b;
    vec_t        xs;
    vec_t        ws;
    logic [63:0] y;
    logic        s;
  } vec_rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  act_func     act;
  sfp          bias;
  logic        in_valid;
  logic        in_ready;
  sfp          x;
  sfp          w;
  logic        out_valid;
  logic        out_ready;
  sfp          y;
  logic        busy;
  logic        sat;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  perceptron_neuron #(.N_INPUTS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .act(act), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .busy(busy), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: wide-integer arithmetic straight from the neuron's definition
  function automatic void model(input act_func f, input logic [63:0] b, input vec_t xs,
                                input vec_t ws, output logic [63:0] ry, output logic rs);
    logic signed [127:0] a;
    logic signed [127:0] p;
    logic signed [127:0] v;
    logic signed [127:0] one;
    one = 128'sh1_0000_0000;
    a   = $signed(b);
    rs  = 1'b0;
    for (int i = 0; i < N; i++) begin
      p = $signed(xs[i]) * $signed(ws[i]);
      p = p >>> 32;
      p = $signed(p[63:0]);
      a = a + p;
`ifdef PERCEPTRON_ACC_SATURATE_EN
      if (a > 128'sh7FFF_FFFF_FFFF_FFFF) begin
        a = 128'sh7FFF_FFFF_FFFF_FFFF; rs = 1'b1;
      end else if (a < -(128'sh8000_0000_0000_0000)) begin
        a = -(128'sh8000_0000_0000_0000); rs = 1'b1;
      end
`else
      a = $signed(a[63:0]);
`endif
    end
    case (f)
      ACT_STEP: v = (a >= 0) ? one : 128'sd0;
      ACT_RELU: v = (a >= 0) ? a : 128'sd0;
      ACT_SIGMOID: begin
        v = (a >>> 2) + 128'sh8000_0000;
        if (v < 0) v = 0;
        if (v > one) v = one;
      end
      default: begin
        v = a;
        if (v < -one) v = -one;
        if (v > one) v = one;
      end
    endcase
    ry = v[63:0];
  endfunction

  task automatic run_eval(input string tag, input act_func f, input logic [63:0] b,
                          input vec_t xs, input vec_t ws, input bit gaps, input int hold,
                          input logic [63:0] exp_y, input logic exp_s, input int exp_lat);
    int  idx;
    bit  iv;
    logic rdy;
    cyc   = 0;
    start = 1'b1;
    act   = f;
    bias  = b;
    step();
    start = 1'b0;
    act   = act_func'(2'($urandom_range(0, 3)));
    bias  = {$urandom, $urandom};
    idx   = 0;
    while (idx < N && cyc < 200) begin
      iv       = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid = iv;
      x        = iv ? xs[idx] : {$urandom, $urandom};
      w        = iv ? ws[idx] : {$urandom, $urandom};
      rdy      = in_ready;
      step();
      if (iv && rdy) idx++;
    end
    in_valid = 1'b0;
    x = {$urandom, $urandom};
    w = {$urandom, $urandom};
    while (!out_valid && cyc < 200) step();
    if (!out_valid) begin
      check({tag, ".timeout"}, 64'(out_valid), 64'd1);
      return;
    end
    if (exp_lat >= 0) check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, ".y"}, y, exp_y);
    check({tag, ".sat"}, 64'(sat), 64'(exp_s));
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      start     = 1'b1;
      step();
      check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".hold_y"}, y, exp_y);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".busy_after"}, 64'(busy), 64'd0);
    check({tag, ".valid_after"}, 64'(out_valid), 64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    logic signed [63:0] v;
    v = {$urandom, $urandom};
    return v >>> $urandom_range(0, 40);
  endfunction

  vec_rec_t    tbl[10];
  vec_t        xs1234;
  vec_t        w_half;
  vec_t        x_one;
  vec_t        zeros;
  vec_t        ovx;
  vec_t        rxs;
  vec_t        rws;
  logic [63:0] ey;
  logic        es;

  initial begin
    rst = 1'b1; start = 1'b0; act = ACT_STEP; bias = '0;
    in_valid = 1'b0; x = '0; w = '0; out_ready = 1'b0;
    repeat (3) step();
    check("reset.in_ready", 64'(in_ready), 64'd0);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.y", y, 64'd0);
    check("reset.sat", 64'(sat), 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < N; i++) begin
      xs1234[i] = 64'(i + 1) << 32;
      w_half[i] = HALF;
      x_one[i]  = ONE;
      zeros[i]  = '0;
      ovx[i]    = (i == 0) ? ONE : 64'd0;
    end

    tbl[0] = '{ACT_RELU,    64'd0,                   xs1234, w_half, 64'h5_0000_0000, 1'b0};
    tbl[1] = '{ACT_RELU,    64'hFFFF_FFFD_0000_0000, x_one,  w_half, 64'd0,           1'b0};
    tbl[2] = '{ACT_STEP,    64'hFFFF_FFFD_0000_0000, x_one,  w_half, 64'd0,           1'b0};
    tbl[3] = '{ACT_STEP,    64'hFFFF_FFFE_0000_0000, x_one,  w_half, ONE,             1'b0};
    tbl[4] = '{ACT_SIGMOID, 64'd0,                   zeros,  zeros,  HALF,            1'b0};
    tbl[5] = '{ACT_SIGMOID, 64'h4_0000_0000,         zeros,  zeros,  ONE,             1'b0};
    tbl[6] = '{ACT_SIGMOID, 64'hFFFF_FFFD_0000_0000, zeros,  zeros,  64'd0,           1'b0};
    tbl[7] = '{ACT_TANH,    64'hFFFF_FFFF_8000_0000, zeros,  zeros,  64'hFFFF_FFFF_8000_0000, 1'b0};
    tbl[8] = '{ACT_TANH,    64'h3_0000_0000,         zeros,  zeros,  ONE,             1'b0};
`ifdef PERCEPTRON_ACC_SATURATE_EN
    tbl[9] = '{ACT_RELU,    64'h7FFF_FFFF_0000_0000, ovx,    ovx,    64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
`else
    tbl[9] = '{ACT_RELU,    64'h7FFF_FFFF_0000_0000, ovx,    ovx,    64'd0,           1'b0};
`endif

    for (int i = 0; i < 10; i++)
      run_eval($sformatf("vec%0d", i), tbl[i].f, tbl[i].b, tbl[i].xs, tbl[i].ws,
               1'b0, 0, tbl[i].y, tbl[i].s, N + 2);

    // Input gaps plus five stalled DONE cycles with ignored start pulses
    run_eval("gaps_hold", ACT_RELU, 64'd0, xs1234, w_half, 1'b1, 5, 64'h5_0000_0000, 1'b0, -1);

    // Abort after two beats, then a clean evaluation must show no residue
    start = 1'b1; act = ACT_RELU; bias = 64'h7_0000_0000;
    step();
    start = 1'b0; in_valid = 1'b1; x = ONE; w = ONE;
    step();
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    check("abort.in_ready", 64'(in_ready), 64'd0);
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.y", y, 64'd0);
    rst = 1'b0;
    step();
    run_eval("after_abort", ACT_RELU, 64'd0, xs1234, w_half, 1'b0, 0, 64'h5_0000_0000, 1'b0, N + 2);

    for (int r = 0; r < 25; r++) begin
      act_func rf;
      logic [63:0] rb;
      rf = act_func'(2'($urandom_range(0, 3)));
      rb = ($urandom_range(0, 4) == 0) ? {$urandom, $urandom} : rnd64();
      for (int i = 0; i < N; i++) begin
        rxs[i] = rnd64();
        rws[i] = rnd64();
      end
      model(rf, rb, rxs, rws, ey, es);
      run_eval($sformatf("rand%0d", r), rf, rb, rxs, rws, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)), ey, es, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
